// File: rtl/comparator_seq_pkg.sv
// Shared types and constants for the nibble-serial 8-bit magnitude comparator.
// Holds the FSM state encoding and the one-hot {eq,gt,lt} result encodings.
package comparator_seq_pkg;

    localparam int NIBBLE_W  = 4;
    localparam int OPERAND_W = 2 * NIBBLE_W;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HI   = 2'b01,
        LO   = 2'b10,
        DONE = 2'b11
    } state_t;

    typedef struct packed {
        logic eq;
        logic gt;
        logic lt;
    } rel_t;

    localparam rel_t REL_NONE = 3'b000;
    localparam rel_t REL_EQ   = 3'b100;
    localparam rel_t REL_GT   = 3'b010;
    localparam rel_t REL_LT   = 3'b001;

endpackage

// File: rtl/magnitude_comparator_4_bits.sv
// Purpose: combinational unsigned compare of two nibbles, one-hot eq/gt/lt.
// Latency: zero cycles (pure combinational).
// Backpressure: none; outputs follow inputs continuously.
module magnitude_comparator_4_bits
    import comparator_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    output logic                eq,
    output logic                gt,
    output logic                lt
);

    assign eq = (a == b);
    assign gt = (a >  b);
    assign lt = (a <  b);

endmodule

// File: rtl/comparator_sequencer_8_bits.sv
// Purpose: 8-bit unsigned compare by time-sharing one 4-bit comparator over hi then lo nibble.
// Latency: done 3 cycles after accepting start; 2 when CMP_SEQ_EARLY_EXIT_EN and hi nibbles differ.
// Backpressure: start is accepted only while busy=0 (IDLE or DONE); starts during busy are dropped.
module comparator_sequencer_8_bits
    import comparator_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [OPERAND_W-1:0] A,
    input  logic [OPERAND_W-1:0] B,
    output logic                 busy,
    output logic                 done,
    output logic                 eq,
    output logic                 gt,
    output logic                 lt
);

    state_t               state;
    logic [OPERAND_W-1:0] a_r;
    logic [OPERAND_W-1:0] b_r;
    rel_t                 hi_rel;
    rel_t                 res;

    logic [NIBBLE_W-1:0]  cmp_a;
    logic [NIBBLE_W-1:0]  cmp_b;
    logic                 cmp_eq;
    logic                 cmp_gt;
    logic                 cmp_lt;
    rel_t                 cmp_rel;

    // Mux select depends on state alone so the comparator path stays short.
    assign cmp_a = (state == HI) ? a_r[OPERAND_W-1:NIBBLE_W] : a_r[NIBBLE_W-1:0];
    assign cmp_b = (state == HI) ? b_r[OPERAND_W-1:NIBBLE_W] : b_r[NIBBLE_W-1:0];

    magnitude_comparator_4_bits u_cmp (
        .a  (cmp_a),
        .b  (cmp_b),
        .eq (cmp_eq),
        .gt (cmp_gt),
        .lt (cmp_lt)
    );

    assign cmp_rel = '{eq: cmp_eq, gt: cmp_gt, lt: cmp_lt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_r    <= '0;
            b_r    <= '0;
            hi_rel <= REL_NONE;
            res    <= REL_NONE;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r   <= A;
                        b_r   <= B;
                        busy  <= 1'b1;
                        state <= HI;
                    end
                end
                HI: begin
`ifdef CMP_SEQ_EARLY_EXIT_EN
                    if (!cmp_rel.eq) begin
                        res   <= cmp_rel;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        hi_rel <= cmp_rel;
                        state  <= LO;
                    end
`else
                    hi_rel <= cmp_rel;
                    state  <= LO;
`endif
                end
                LO: begin
                    // A decided high nibble overrides whatever the low nibble says.
                    res   <= hi_rel.eq ? cmp_rel : hi_rel;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r   <= A;
                        b_r   <= B;
                        busy  <= 1'b1;
                        state <= HI;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign eq = res.eq;
    assign gt = res.gt;
    assign lt = res.lt;

endmodule

// File: tb/tb_comparator_sequencer_8_bits.sv
// Directed bench for comparator_sequencer_8_bits: vector table plus hand-written busy/reset sequences.
module tb_comparator_sequencer_8_bits;

`ifdef CMP_SEQ_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic       busy;
    logic       done;
    logic       eq;
    logic       gt;
    logic       lt;

    int n_checks;
    int n_pass;

    comparator_sequencer_8_bits dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .eq    (eq),
        .gt    (gt),
        .lt    (lt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] exp_flags;   // {eq,gt,lt}
        bit         hi_differs;  // selects the 2-cycle path when early exit is built in
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic run_op(input string nm, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] exp_flags, input int exp_lat);
        int got_lat;
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        got_lat = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) check({nm, " busy_c1"}, {7'd0, busy}, 8'd1);
            if (done) begin
                got_lat = i;
                break;
            end
        end
        check({nm, " latency"}, got_lat[7:0], exp_lat[7:0]);
        check({nm, " flags"}, {5'd0, eq, gt, lt}, {5'd0, exp_flags});
        check({nm, " busy_done"}, {7'd0, busy}, 8'd0);
        @(negedge clk);
        check({nm, " done_pulse"}, {7'd0, done}, 8'd0);
        check({nm, " flags_hold"}, {5'd0, eq, gt, lt}, {5'd0, exp_flags});
    endtask

    initial begin
        int done_seen;
        n_checks = 0;
        n_pass   = 0;
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0;

        vecs[0] = '{8'h5A, 8'h5A, 3'b100, 1'b0};
        vecs[1] = '{8'h91, 8'h3F, 3'b010, 1'b1};
        vecs[2] = '{8'h47, 8'h4C, 3'b001, 1'b0};
        vecs[3] = '{8'h3F, 8'h91, 3'b001, 1'b1};
        vecs[4] = '{8'hA5, 8'hA3, 3'b010, 1'b0};
        vecs[5] = '{8'h00, 8'h00, 3'b100, 1'b0};
        vecs[6] = '{8'hFF, 8'hFE, 3'b010, 1'b0};
        vecs[7] = '{8'h00, 8'hFF, 3'b001, 1'b1};
        vecs[8] = '{8'h80, 8'h7F, 3'b010, 1'b1};

        // Reset state after release and five idle cycles.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rst busy", {7'd0, busy}, 8'd0);
        check("rst done", {7'd0, done}, 8'd0);
        check("rst eq",   {7'd0, eq},   8'd0);
        check("rst gt",   {7'd0, gt},   8'd0);
        check("rst lt",   {7'd0, lt},   8'd0);

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp_flags,
                   (EARLY && vecs[i].hi_differs) ? 2 : 3);

        // Start while busy is dropped; start in DONE is taken at once.
        @(negedge clk);
        A = 8'h37; B = 8'h35; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("bsy c1 busy", {7'd0, busy}, 8'd1);
        A = 8'h00; B = 8'hFF; start = 1'b1;
        @(negedge clk);
        check("bsy c2 busy", {7'd0, busy}, 8'd1);
        check("bsy c2 done", {7'd0, done}, 8'd0);
        start = 1'b0;
        @(negedge clk);
        check("bsy c3 done", {7'd0, done}, 8'd1);
        check("bsy flags", {5'd0, eq, gt, lt}, 8'b010);
        A = 8'h22; B = 8'h22; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("b2b c1 busy", {7'd0, busy}, 8'd1);
        check("b2b c1 done", {7'd0, done}, 8'd0);
        @(negedge clk);
        @(negedge clk);
        check("b2b c3 done", {7'd0, done}, 8'd1);
        check("b2b flags", {5'd0, eq, gt, lt}, 8'b100);

        // Reset asserted during LO aborts the request.
        @(negedge clk);
        A = 8'h5A; B = 8'h5B; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst busy",  {7'd0, busy}, 8'd0);
        check("arst done",  {7'd0, done}, 8'd0);
        check("arst flags", {5'd0, eq, gt, lt}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("arst no_done", done_seen[7:0], 8'd0);
        check("arst idle",    {7'd0, busy}, 8'd0);
        check("arst flags_after", {5'd0, eq, gt, lt}, 8'd0);
        run_op("post_rst", 8'hC3, 8'hC1, 3'b010, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
